mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Shares the single-port unified RAM between the instruction-fetch port and the data (LW/SW) port of the processor datapath.
- Sequences each access as a multi-cycle RAM transaction and returns ihit/dhit to the requester.
- Freezes all traffic once the control path raises halt.
- Sits between the fetch/memory stages and the RAM model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles waited for ram_ready before abort; 4-bit counter, legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- ihit  out  1  instruction access complete, 1-cycle pulse
- iload  out  DATA_W  instruction word, valid when ihit=1
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dhit  out  1  data access complete, 1-cycle pulse
- dload  out  DATA_W  read data, valid when dhit=1 and the access was a read
- halt  in  1  processor halt
- ram_ren  out  1  RAM read enable
- ram_wen  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data
- ram_ready  in  1  RAM transaction complete
- err  out  1  sticky; set on timeout

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, latched address/data/we cleared, timeout counter=0.
  - All outputs 0: ihit, dhit, iload, dload, ram_*, err.
- FSM states: IDLE, IBUSY, DBUSY, HALTED.
- IDLE:
  - halt=1 -> HALTED; halt has priority over pending requests.
  - else (dREN|dWEN) -> DBUSY. Latch daddr, dstore, we=dWEN. If dREN and dWEN are both set, treat as a write.
  - else iREN -> IBUSY. Latch iaddr.
  - else stay IDLE.
  - Data has fixed priority over instruction.
- IBUSY/DBUSY:
  - ram_addr = latched address; ram_store = latched data.
  - ram_ren = 1 for a read; ram_wen = 1 for a data write. Never both.
  - Drive from registered values so that outputs are glitch-free.
  - Counter increments each cycle that ram_ready=0.
  - ram_ready=1: hit for the active port is combinational in that same cycle; iload/dload = ram_load passthrough. Next state IDLE, counter cleared.
  - Counter reaches TIMEOUT with no ram_ready: err<=1, no hit, -> IDLE.
- Latency and requester rules:
  - Minimum latency is 2 cycles: request seen in IDLE, hit in the next cycle if ram_ready is immediate.
  - Back-to-back accesses are separated by one IDLE cycle.
  - Requesters hold request/address until hit. Changes to iaddr/daddr during BUSY are ignored (latched copy is used).
  - A request dropped mid-transaction still completes on the RAM. The hit still pulses and may be ignored.
- halt asserted during BUSY: the current access completes normally (hit pulses), then -> HALTED.
- HALTED: ram_ren=ram_wen=0, ihit=dhit=0, requests ignored. Only rst exits.
- Hits only pulse for the port that owns the current transaction; ihit and dhit are never 1 together.
- err stays 1 until rst.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined: a 2-bit counter tracks consecutive data grants that occurred while iREN=1. After 3 such grants, the next IDLE arbitration grants the instruction port even if a data request is pending; the counter then clears. The counter also clears on any instruction grant.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- rst pulse mid-DBUSY with ram_wen=1 -> all outputs 0 immediately (async), state IDLE, no dhit.
- iREN=1, iaddr=0x0000_0040, ram_ready one cycle after ram_ren, ram_load=0x2408_0005 -> ram_addr=0x40, ihit=1 with iload=0x2408_0005 in cycle 3; next cycle IDLE.
- iREN=1 and dWEN=1 together, daddr=0x80, dstore=0xDEAD_BEEF -> ram_wen=1 with ram_addr=0x80 first; dhit; one IDLE cycle; then IBUSY and ihit.
- dREN=1, ram_ready never asserted, TIMEOUT=15 -> after 15 BUSY cycles err=1, no dhit, returns to IDLE; err stays 1.
- halt=1 during IBUSY -> ihit pulses when ram_ready arrives, then HALTED; subsequent iREN/dREN give ram_ren=0 for 20 cycles.
- ARB_FAIR_EN defined, iREN and dREN held continuously -> grant order D,D,D,I,D,D,D,I; undefined -> D only, no ihit.

Source files
------------

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: shares a single-port RAM between the instruction-fetch
// port and the data (LW/SW) port. Each access is one multi-cycle RAM
// transaction that ends with a one-cycle ihit/dhit. Data has priority over
// instruction. halt freezes all traffic after any in-flight access completes.
// An access that waits TIMEOUT cycles for ram_ready is abandoned and sets
// the sticky err flag.
//
// Build option ARB_FAIR_EN: after three consecutive data grants made while
// iREN was pending, the next arbitration goes to the instruction port.
// Without the macro, data priority is strict and the fairness counter is
// not built.
module mem_arbiter_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  input  logic              halt,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_ready,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IBUSY  = 2'd1,
    DBUSY  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // A busy state gives up on the cycle in which the wait counter would
  // reach TIMEOUT, so a transaction spans at most TIMEOUT busy cycles.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              halt_pend_q, halt_pend_d;
  logic              i_turn;

`ifdef ARB_FAIR_EN
  logic [1:0]        fair_q, fair_d;

  // Instruction port wins this arbitration once three data grants in a row
  // have starved a pending fetch.
  assign i_turn = iREN && (fair_q == 2'd3);

  // Fairness streak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fair_q <= '0;
    end else begin
      fair_q <= fair_d;
    end
  end
`else
  assign i_turn = 1'b0;
`endif

  // State and transaction latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next-state, arbitration and output decode; RAM strobes come only from
  // registered state so they cannot glitch, hits follow ram_ready directly.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    halt_pend_d = halt_pend_q;
`ifdef ARB_FAIR_EN
    fair_d      = fair_q;
`endif
    ihit        = 1'b0;
    dhit        = 1'b0;
    iload       = '0;
    dload       = '0;
    ram_ren     = 1'b0;
    ram_wen     = 1'b0;
    ram_addr    = '0;
    ram_store   = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (halt) begin
          state_d = HALTED;
        end else if ((dREN || dWEN) && !i_turn) begin
          state_d = DBUSY;
          addr_d  = daddr;
          data_d  = dstore;
          we_d    = dWEN;
`ifdef ARB_FAIR_EN
          fair_d  = iREN ? fair_q + 2'd1 : '0;
`endif
        end else if (iREN) begin
          state_d = IBUSY;
          addr_d  = iaddr;
          we_d    = 1'b0;
`ifdef ARB_FAIR_EN
          fair_d  = '0;
`endif
        end
      end

      IBUSY, DBUSY: begin
        ram_addr  = addr_q;
        ram_store = data_q;
        ram_wen   = (state_q == DBUSY) && we_q;
        ram_ren   = !ram_wen;
        if (halt) begin
          halt_pend_d = 1'b1;
        end
        if (ram_ready) begin
          if (state_q == IBUSY) begin
            ihit  = 1'b1;
            iload = ram_load;
          end else begin
            dhit  = 1'b1;
            dload = we_q ? '0 : ram_load;
          end
          cnt_d   = '0;
          state_d = (halt || halt_pend_q) ? HALTED : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = (halt || halt_pend_q) ? HALTED : IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    err = err_q;
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: requester tasks push expected transactions into
// per-port queues, a negedge monitor pops and compares on each hit. A RAM
// model with configurable latency backs the DUT; a reference memory tracks
// what each read must return.
module tb_mem_arbiter_ctrl;

  logic        clk;
  logic        rst;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        halt;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic        err;

  mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload), .halt(halt),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_ready(ram_ready),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] load;
    int          exp_cyc;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  bit   order_q[$];
  bit   order_chk = 1'b0;

  logic [31:0] ref_mem [0:127];
  logic [31:0] ram_mem [0:127];
  int          ram_lat  = 0;
  bit          rand_lat = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // RAM model: ready arrives after cur_lat stalled busy cycles.
  initial begin
    int busy_cnt;
    int cur_lat;
    busy_cnt  = 0;
    cur_lat   = 0;
    ram_ready = 1'b0;
    ram_load  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ram_ren || ram_wen) begin
        busy_cnt++;
        if (busy_cnt == 1) cur_lat = rand_lat ? int'($urandom_range(0, 3)) : ram_lat;
        if (busy_cnt > cur_lat) begin
          ram_ready = 1'b1;
          if (ram_wen) begin
            ram_mem[ram_addr[8:2]] = ram_store;
            ram_load = $urandom;
          end else begin
            ram_load = ram_mem[ram_addr[8:2]];
          end
        end else begin
          ram_ready = 1'b0;
          ram_load  = $urandom;
        end
      end else begin
        busy_cnt  = 0;
        ram_ready = 1'b0;
        ram_load  = $urandom;
      end
    end
  end

  task automatic check_order;
    bit want_d;
    if (order_q.size() == 0) begin
      check("grant_order_extra", 32'(ihit | dhit), 32'd0);
    end else begin
      want_d = order_q.pop_front();
      check("grant_order", 32'(dhit), 32'(want_d));
    end
  endtask

  // Monitor: pops the owning port's queue on every hit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (ihit || dhit) check("hit_exclusive", 32'(ihit & dhit), 32'd0);
      if (ihit) begin
        if (iq.size() == 0) begin
          check("unexpected_ihit", 32'(ihit), 32'd0);
        end else begin
          e = iq.pop_front();
          check("i_ram_ren", 32'(ram_ren), 32'd1);
          check("i_ram_wen", 32'(ram_wen), 32'd0);
          check("i_ram_addr", ram_addr, e.addr);
          check("iload", iload, e.load);
          if (e.exp_cyc >= 0) check("ihit_cycle", cyc, e.exp_cyc);
          if (order_chk) check_order();
        end
      end
      if (dhit) begin
        if (dq.size() == 0) begin
          check("unexpected_dhit", 32'(dhit), 32'd0);
        end else begin
          e = dq.pop_front();
          check("d_ram_wen", 32'(ram_wen), 32'(e.we));
          check("d_ram_ren", 32'(ram_ren), 32'(!e.we));
          check("d_ram_addr", ram_addr, e.addr);
          if (e.we) check("ram_store", ram_store, e.wdata);
          else      check("dload", dload, e.load);
          if (e.exp_cyc >= 0) check("dhit_cycle", cyc, e.exp_cyc);
          if (order_chk) check_order();
        end
      end
    end
  end

  // Instruction requester: hold until ihit, release on the next cycle.
  task automatic do_i(input logic [31:0] addr, input int exp_cyc);
    exp_t e;
    int   n;
    e.addr = addr; e.we = 1'b0; e.wdata = '0;
    e.load = ref_mem[addr[8:2]]; e.exp_cyc = exp_cyc;
    iq.push_back(e);
    iREN = 1'b1; iaddr = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (!ihit && n < 400);
    if (!ihit) check("ihit_wait", 32'(ihit), 32'd1);
    @(posedge clk); #1;
    iREN = 1'b0; iaddr = $urandom;
  endtask

  // Data requester: both strobes set means a write.
  task automatic do_d(input logic [31:0] addr, input bit rd, input bit wr,
                      input logic [31:0] wdata, input int exp_cyc);
    exp_t e;
    int   n;
    e.addr = addr; e.we = wr; e.wdata = wdata;
    e.load = ref_mem[addr[8:2]]; e.exp_cyc = exp_cyc;
    dq.push_back(e);
    if (wr) ref_mem[addr[8:2]] = wdata;
    dREN = rd; dWEN = wr; daddr = addr; dstore = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!dhit && n < 400);
    if (!dhit) check("dhit_wait", 32'(dhit), 32'd1);
    @(posedge clk); #1;
    dREN = 1'b0; dWEN = 1'b0; daddr = $urandom; dstore = $urandom;
  endtask

  // Expected grant sequence with both ports continuously requesting.
  task automatic build_order(input int nd, input int ni);
    int streak;
    bit fair_turn;
    streak = 0;
    order_q.delete();
    while (nd > 0 || ni > 0) begin
      fair_turn = 1'b0;
`ifdef ARB_FAIR_EN
      fair_turn = (streak == 3);
`endif
      if (ni > 0 && (nd == 0 || fair_turn)) begin
        order_q.push_back(1'b0); ni--; streak = 0;
      end else begin
        order_q.push_back(1'b1); nd--;
        if (ni > 0) streak++;
      end
    end
  endtask

  task automatic do_reset;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    rst = 1'b1;
    iq.delete(); dq.delete(); order_q.delete(); order_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; halt = 1'b0;
    for (int k = 0; k < 128; k++) begin
      ref_mem[k] = $urandom;
      ram_mem[k] = ref_mem[k];
    end
    ref_mem[16] = 32'h2408_0005;
    ram_mem[16] = 32'h2408_0005;

    // Reset values.
    @(negedge clk);
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_dhit", 32'(dhit), 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
    check("rst_ram_ren", 32'(ram_ren), 32'd0);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_store", ram_store, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Async reset in the middle of a write.
    ram_lat = 1000;
    @(posedge clk); #1;
    dWEN = 1'b1; daddr = 32'h108; dstore = 32'h1234_5678;
    @(posedge clk); #1;
    @(negedge clk);
    check("midwr_ram_wen", 32'(ram_wen), 32'd1);
    check("midwr_ram_addr", ram_addr, 32'h108);
    #2 rst = 1'b1;
    #1;
    check("arst_ram_wen", 32'(ram_wen), 32'd0);
    check("arst_ram_ren", 32'(ram_ren), 32'd0);
    check("arst_ram_addr", ram_addr, 32'd0);
    check("arst_ram_store", ram_store, 32'd0);
    check("arst_dhit", 32'(dhit), 32'd0);
    dWEN = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Single fetch, ready one cycle after ram_ren.
    ram_lat = 1;
    @(posedge clk); #1;
    c = cyc;
    do_i(32'h40, c + 2);
    @(negedge clk);
    check("idle_after_ihit", 32'(ram_ren | ram_wen), 32'd0);

    // Simultaneous fetch and store: data first, one IDLE gap, then fetch.
    do_reset();
    ram_lat = 1;
    order_q.push_back(1'b1); order_q.push_back(1'b0); order_chk = 1'b1;
    @(posedge clk); #1;
    c = cyc;
    fork
      do_d(32'h80, 1'b0, 1'b1, 32'hDEAD_BEEF, c + 2);
      do_i(32'h44, c + 5);
    join
    order_chk = 1'b0;
    check("order_left_a", order_q.size(), 32'd0);

    // Both ports requesting continuously.
    do_reset();
    ram_lat = 1;
    build_order(8, 2);
    order_chk = 1'b1;
    @(posedge clk); #1;
    fork
      for (int k = 0; k < 8; k++)
        do_d(32'h100 + 32'($urandom_range(0, 31)) * 4, 1'b1, 1'b0, '0, -1);
      for (int k = 0; k < 2; k++)
        do_i(32'($urandom_range(0, 31)) * 4, -1);
    join
    order_chk = 1'b0;
    check("order_left_b", order_q.size(), 32'd0);

    // Random concurrent traffic with random RAM latency.
    do_reset();
    rand_lat = 1'b1;
    @(posedge clk); #1;
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_i(32'($urandom_range(0, 31)) * 4, -1);
      end
      for (int k = 0; k < 40; k++) begin
        int op;
        op = int'($urandom_range(0, 2));
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        do_d(32'h100 + 32'($urandom_range(0, 31)) * 4, op != 1, op != 0, $urandom, -1);
      end
    join
    rand_lat = 1'b0;

    // Timeout: 15 busy cycles, no hit, err sticky.
    do_reset();
    ram_lat = 1000;
    @(posedge clk); #1;
    dREN = 1'b1; daddr = 32'h104;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("to_last_busy_ren", 32'(ram_ren), 32'd1);
    check("to_err_before", 32'(err), 32'd0);
    @(posedge clk); #1;
    dREN = 1'b0;
    @(negedge clk);
    check("to_idle_ren", 32'(ram_ren), 32'd0);
    check("to_err_set", 32'(err), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check("err_sticky", 32'(err), 32'd1);
    end
    ram_lat = 0;
    @(posedge clk); #1;
    c = cyc;
    do_d(32'h104, 1'b1, 1'b0, '0, c + 1);
    check("err_sticky_after_hit", 32'(err), 32'd1);

    // Halt during IBUSY: access completes, then frozen.
    do_reset();
    ram_lat = 3;
    @(posedge clk); #1;
    c = cyc;
    fork
      do_i(32'h10, c + 4);
      begin
        repeat (2) begin @(posedge clk); #1; end
        halt = 1'b1;
      end
    join
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h20; daddr = 32'h110;
    repeat (20) begin
      @(negedge clk);
      check("halted_ram_ren", 32'(ram_ren), 32'd0);
      check("halted_ram_wen", 32'(ram_wen), 32'd0);
    end

    // Halt in IDLE beats pending requests.
    do_reset();
    @(posedge clk); #1;
    halt = 1'b1; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h8; daddr = 32'h100;
    repeat (3) begin
      @(negedge clk);
      check("halt_idle_ram_ren", 32'(ram_ren), 32'd0);
    end
    do_reset();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
